// File: rtl/cva6_hpdcache_read_mux_nport_if.sv
`default_nettype none
// ============================================================================
// Module   : cva6_hpdcache_read_mux_nport_if
// Purpose  : Bundle of all request, downstream-memory and response signals of
//            the N-port read multiplexer. The "slave" modport is the mux side
//            (it serves the requesters and drives the memory request); the
//            "master" modport is the environment side (requesters + memory).
// Revision : 1.0 - initial release
// ============================================================================
interface cva6_hpdcache_read_mux_nport_if #(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 64,
    parameter int ID_W   = 4,
    parameter int DATA_W = 64
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int MID_W = ID_W + IDX_W;

    // Requester side
    logic [NREQ-1:0]        req_valid_i;
    logic [NREQ-1:0]        req_ready_o;
    logic [NREQ*ADDR_W-1:0] req_addr_i;
    logic [NREQ*8-1:0]      req_len_i;
    logic [NREQ*ID_W-1:0]   req_id_i;

    // Downstream request
    logic                   mem_req_valid_o;
    logic                   mem_req_ready_i;
    logic [ADDR_W-1:0]      mem_req_addr_o;
    logic [7:0]             mem_req_len_o;
    logic [MID_W-1:0]       mem_req_id_o;

    // Downstream response
    logic                   mem_resp_valid_i;
    logic                   mem_resp_ready_o;
    logic [MID_W-1:0]       mem_resp_id_i;
    logic [DATA_W-1:0]      mem_resp_data_i;
    logic                   mem_resp_last_i;
    logic                   mem_resp_error_i;

    // Per-requester response (payload shared)
    logic [NREQ-1:0]        resp_valid_o;
    logic [NREQ-1:0]        resp_ready_i;
    logic [ID_W-1:0]        resp_id_o;
    logic [DATA_W-1:0]      resp_data_o;
    logic                   resp_last_o;
    logic                   resp_error_o;

    // Status
    logic [NREQ-1:0]        outst_full_o;
    logic                   unrouted_o;

    modport slave (
        input  req_valid_i, req_addr_i, req_len_i, req_id_i,
        output req_ready_o,
        output mem_req_valid_o, mem_req_addr_o, mem_req_len_o, mem_req_id_o,
        input  mem_req_ready_i,
        input  mem_resp_valid_i, mem_resp_id_i, mem_resp_data_i, mem_resp_last_i, mem_resp_error_i,
        output mem_resp_ready_o,
        output resp_valid_o, resp_id_o, resp_data_o, resp_last_o, resp_error_o,
        input  resp_ready_i,
        output outst_full_o, unrouted_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_len_i, req_id_i,
        input  req_ready_o,
        input  mem_req_valid_o, mem_req_addr_o, mem_req_len_o, mem_req_id_o,
        output mem_req_ready_i,
        output mem_resp_valid_i, mem_resp_id_i, mem_resp_data_i, mem_resp_last_i, mem_resp_error_i,
        input  mem_resp_ready_o,
        input  resp_valid_o, resp_id_o, resp_data_o, resp_last_o, resp_error_o,
        output resp_ready_i,
        input  outst_full_o, unrouted_o
    );
endinterface
`default_nettype wire

// File: rtl/cva6_hpdcache_read_mux_nport.sv
`default_nettype none
// ============================================================================
// Module   : cva6_hpdcache_read_mux_nport
// Purpose  : Round-robin multiplexer of NREQ read requesters onto one memory
//            request channel. The port index is prepended to the transaction
//            ID so responses can be routed back per beat. A per-port counter
//            limits outstanding bursts to MAX_OUTST.
// Revision : 1.0 - initial release
// ============================================================================
module cva6_hpdcache_read_mux_nport #(
    parameter int NREQ      = 2,
    parameter int ADDR_W    = 64,
    parameter int ID_W      = 4,
    parameter int DATA_W    = 64,
    parameter int MAX_OUTST = 4
) (
    input  wire logic                         clk_i,
    input  wire logic                         rst_ni,
    cva6_hpdcache_read_mux_nport_if.slave     bus
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int MID_W = ID_W + IDX_W;
    localparam int CNT_W = $clog2(MAX_OUTST + 1);
    // Eligibility vector padded to a power of two so any IDX_W-bit index is
    // in range.
    localparam int NPAD  = 1 << IDX_W;

    localparam logic [IDX_W:0]   C_NREQ      = (IDX_W+1)'(NREQ);
    localparam logic [CNT_W-1:0] C_MAX_OUTST = CNT_W'(MAX_OUTST);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]  rr_ptr_q,    rr_ptr_d;
    logic              out_valid_q, out_valid_d;
    logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
    logic [7:0]        out_len_q,   out_len_d;
    logic [MID_W-1:0]  out_id_q,    out_id_d;
    logic [CNT_W-1:0]  cnt_q [NREQ];
    logic [CNT_W-1:0]  cnt_d [NREQ];
    logic              unrouted_q,  unrouted_d;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [NPAD-1:0]   eligible;
    logic              grant_found;
    logic [IDX_W-1:0]  grant_idx;
    logic [IDX_W:0]    cand;
    logic [NREQ-1:0]   grant_oh;
    logic              can_load;
    logic              accept;
    logic [IDX_W:0]    ptr_next_sum;

    logic [IDX_W-1:0]  resp_idx;
    logic              resp_routed;
    logic [NREQ-1:0]   resp_sel;
    logic              resp_ready_sel;

    logic [NREQ-1:0]   cnt_inc;
    logic [NREQ-1:0]   cnt_dec;

    // A port may compete only while it still has outstanding-credit left
    always_comb begin
        eligible = '0;
        for (int p = 0; p < NREQ; p++) begin
            eligible[p] = bus.req_valid_i[p] && (cnt_q[p] < C_MAX_OUTST);
        end
    end

    // Round-robin search starting at the priority pointer, wrapping mod NREQ
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
            if (cand >= C_NREQ) begin
                cand = cand - C_NREQ;
            end
            if (!grant_found && eligible[cand[IDX_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // One-hot grant vector for the winner
    always_comb begin
        grant_oh = '0;
        for (int p = 0; p < NREQ; p++) begin
            grant_oh[p] = grant_found && (grant_idx == IDX_W'(p));
        end
    end

    // The output register accepts a new entry when empty or draining this cycle.
    // Ready is forced low while reset is held so nothing is handshaken then.
    assign can_load        = !out_valid_q || bus.mem_req_ready_i;
    assign bus.req_ready_o = grant_oh & {NREQ{can_load & rst_ni}};
    assign accept          = |bus.req_ready_o;

    // Output register, priority pointer and sticky-flag next state
    always_comb begin
        out_valid_d  = out_valid_q;
        out_addr_d   = out_addr_q;
        out_len_d    = out_len_q;
        out_id_d     = out_id_q;
        rr_ptr_d     = rr_ptr_q;
        ptr_next_sum = {1'b0, grant_idx} + (IDX_W+1)'(1);

        if (can_load) begin
            out_valid_d = accept;
        end
        for (int p = 0; p < NREQ; p++) begin
            if (accept && grant_oh[p]) begin
                out_addr_d = bus.req_addr_i[p*ADDR_W +: ADDR_W];
                out_len_d  = bus.req_len_i[p*8 +: 8];
                out_id_d   = {IDX_W'(p), bus.req_id_i[p*ID_W +: ID_W]};
            end
        end
        if (accept) begin
            rr_ptr_d = (ptr_next_sum >= C_NREQ) ? '0 : ptr_next_sum[IDX_W-1:0];
        end

        unrouted_d = unrouted_q | (bus.mem_resp_valid_i & ~resp_routed);
    end

    assign bus.mem_req_valid_o = out_valid_q;
    assign bus.mem_req_addr_o  = out_addr_q;
    assign bus.mem_req_len_o   = out_len_q;
    assign bus.mem_req_id_o    = out_id_q;

    // Decode the port index carried in the upper ID bits of each beat;
    // out-of-range indices are swallowed (ready held high)
    always_comb begin
        resp_idx       = bus.mem_resp_id_i[MID_W-1:ID_W];
        resp_routed    = 1'b0;
        resp_ready_sel = 1'b1;
        resp_sel       = '0;
        for (int p = 0; p < NREQ; p++) begin
            if (resp_idx == IDX_W'(p)) begin
                resp_routed    = 1'b1;
                resp_ready_sel = bus.resp_ready_i[p];
                resp_sel[p]    = 1'b1;
            end
        end
    end

    assign bus.resp_valid_o     = resp_sel & {NREQ{bus.mem_resp_valid_i}};
    assign bus.mem_resp_ready_o = resp_ready_sel;
    assign bus.resp_id_o        = bus.mem_resp_id_i[ID_W-1:0];
    assign bus.resp_data_o      = bus.mem_resp_data_i;
    assign bus.resp_last_o      = bus.mem_resp_last_i;
    assign bus.resp_error_o     = bus.mem_resp_error_i;
    assign bus.unrouted_o       = unrouted_q;

    // Per-port credit events and full flag
    for (genvar gp = 0; gp < NREQ; gp++) begin : g_port
        assign cnt_inc[gp] = bus.req_valid_i[gp] & bus.req_ready_o[gp];
        // The non-zero guard keeps late responses (after a reset) harmless
        assign cnt_dec[gp] = bus.mem_resp_valid_i & resp_sel[gp] & bus.resp_ready_i[gp]
                           & bus.mem_resp_last_i & (cnt_q[gp] != '0);
        assign bus.outst_full_o[gp] = (cnt_q[gp] == C_MAX_OUTST);
    end

    // Outstanding counters: simultaneous accept and last-beat leave them unchanged
    always_comb begin
        for (int p = 0; p < NREQ; p++) begin
            cnt_d[p] = cnt_q[p];
            if (cnt_inc[p] && !cnt_dec[p]) begin
                cnt_d[p] = cnt_q[p] + CNT_W'(1);
            end else if (!cnt_inc[p] && cnt_dec[p]) begin
                cnt_d[p] = cnt_q[p] - CNT_W'(1);
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_len_q   <= '0;
            out_id_q    <= '0;
            unrouted_q  <= 1'b0;
            for (int p = 0; p < NREQ; p++) begin
                cnt_q[p] <= '0;
            end
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_len_q   <= out_len_d;
            out_id_q    <= out_id_d;
            unrouted_q  <= unrouted_d;
            for (int p = 0; p < NREQ; p++) begin
                cnt_q[p] <= cnt_d[p];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cva6_hpdcache_read_mux_nport.sv
`default_nettype none
// ============================================================================
// Module   : tb_cva6_hpdcache_read_mux_nport
// Purpose  : Self-checking bench for the N-port read mux: directed scenarios
//            plus randomized traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cva6_hpdcache_read_mux_nport;
    localparam int NREQ      = 3;
    localparam int ADDR_W    = 32;
    localparam int ID_W      = 4;
    localparam int DATA_W    = 32;
    localparam int MAX_OUTST = 2;
    localparam int IDX_W     = 2;
    localparam int MID_W     = ID_W + IDX_W;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    cva6_hpdcache_read_mux_nport_if #(
        .NREQ(NREQ), .ADDR_W(ADDR_W), .ID_W(ID_W), .DATA_W(DATA_W)
    ) bus ();

    cva6_hpdcache_read_mux_nport #(
        .NREQ(NREQ), .ADDR_W(ADDR_W), .ID_W(ID_W), .DATA_W(DATA_W), .MAX_OUTST(MAX_OUTST)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic idle_inputs();
        bus.req_valid_i      = '0;
        bus.req_addr_i       = '0;
        bus.req_len_i        = '0;
        bus.req_id_i         = '0;
        bus.mem_req_ready_i  = 1'b0;
        bus.mem_resp_valid_i = 1'b0;
        bus.mem_resp_id_i    = '0;
        bus.mem_resp_data_i  = '0;
        bus.mem_resp_last_i  = 1'b0;
        bus.mem_resp_error_i = 1'b0;
        bus.resp_ready_i     = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drive_req(input int p, input logic [ADDR_W-1:0] a,
                             input logic [7:0] l, input logic [ID_W-1:0] id);
        bus.req_addr_i[p*ADDR_W +: ADDR_W] = a;
        bus.req_len_i[p*8 +: 8]            = l;
        bus.req_id_i[p*ID_W +: ID_W]       = id;
    endtask

    task automatic drive_resp(input int idx, input logic [ID_W-1:0] id,
                              input logic [DATA_W-1:0] d, input logic last,
                              input logic [NREQ-1:0] rdy);
        bus.mem_resp_valid_i = 1'b1;
        bus.mem_resp_id_i    = {IDX_W'(idx), id};
        bus.mem_resp_data_i  = d;
        bus.mem_resp_last_i  = last;
        bus.mem_resp_error_i = 1'b0;
        bus.resp_ready_i     = rdy;
    endtask

    // ---------------- directed tests ----------------
    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        bus.req_valid_i     = 3'b111;
        bus.mem_req_ready_i = 1'b1;
        @(negedge clk);
        #1;
        total++; if (bus.req_ready_o !== 3'b000) begin bad++; $display("FAIL reset_ready: got %b want 000", bus.req_ready_o); end
        total++; if (bus.mem_req_valid_o !== 1'b0) begin bad++; $display("FAIL reset_mem_valid: got %b want 0", bus.mem_req_valid_o); end
        total++; if (bus.outst_full_o !== 3'b000) begin bad++; $display("FAIL reset_full: got %b want 000", bus.outst_full_o); end
        total++; if (bus.unrouted_o !== 1'b0) begin bad++; $display("FAIL reset_unrouted: got %b want 0", bus.unrouted_o); end
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_rr_alternate();
        logic [NREQ-1:0]  exp_rdy;
        logic [IDX_W-1:0] exp_idx;
        logic [ID_W-1:0]  exp_lid;
        do_reset();
        drive_req(0, 32'h0000_1000, 8'd0, 4'hA);
        drive_req(1, 32'h0000_2000, 8'd1, 4'h5);
        bus.req_valid_i     = 3'b011;
        bus.mem_req_ready_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            exp_rdy = (k >= 4) ? 3'b000 : ((k % 2 == 0) ? 3'b001 : 3'b010);
            total++; if (bus.req_ready_o !== exp_rdy) begin bad++; $display("FAIL rr_ready c%0d: got %b want %b", k, bus.req_ready_o, exp_rdy); end
            if (k >= 1 && k <= 4) begin
                exp_idx = ((k - 1) % 2 == 1) ? 2'd1 : 2'd0;
                exp_lid = ((k - 1) % 2 == 1) ? 4'h5 : 4'hA;
                total++; if (bus.mem_req_valid_o !== 1'b1) begin bad++; $display("FAIL rr_mem_valid c%0d: got %b want 1", k, bus.mem_req_valid_o); end
                total++; if (bus.mem_req_id_o !== {exp_idx, exp_lid}) begin bad++; $display("FAIL rr_mem_id c%0d: got %h want %h", k, bus.mem_req_id_o, {exp_idx, exp_lid}); end
            end
            if (k == 5) begin
                total++; if (bus.mem_req_valid_o !== 1'b0) begin bad++; $display("FAIL rr_drain c%0d: got %b want 0", k, bus.mem_req_valid_o); end
            end
            if (k >= 4) begin
                total++; if (bus.outst_full_o !== 3'b011) begin bad++; $display("FAIL rr_full c%0d: got %b want 011", k, bus.outst_full_o); end
            end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_outst_full();
        do_reset();
        drive_req(0, 32'h0000_3000, 8'd3, 4'h1);
        bus.req_valid_i     = 3'b001;
        bus.mem_req_ready_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            total++; if (bus.req_ready_o !== 3'b001) begin bad++; $display("FAIL full_accept c%0d: got %b want 001", k, bus.req_ready_o); end
            @(negedge clk);
        end
        #1;
        total++; if (bus.outst_full_o !== 3'b001) begin bad++; $display("FAIL full_flag: got %b want 001", bus.outst_full_o); end
        total++; if (bus.req_ready_o !== 3'b000) begin bad++; $display("FAIL full_blocked: got %b want 000", bus.req_ready_o); end
        @(negedge clk);
        drive_resp(0, 4'h1, 32'h1234_5678, 1'b1, 3'b001);
        #1;
        total++; if (bus.req_ready_o !== 3'b000) begin bad++; $display("FAIL full_same_cycle: got %b want 000", bus.req_ready_o); end
        total++; if (bus.resp_valid_o !== 3'b001) begin bad++; $display("FAIL full_resp_valid: got %b want 001", bus.resp_valid_o); end
        total++; if (bus.mem_resp_ready_o !== 1'b1) begin bad++; $display("FAIL full_resp_ready: got %b want 1", bus.mem_resp_ready_o); end
        @(negedge clk);
        bus.mem_resp_valid_i = 1'b0;
        #1;
        total++; if (bus.outst_full_o !== 3'b000) begin bad++; $display("FAIL full_cleared: got %b want 000", bus.outst_full_o); end
        total++; if (bus.req_ready_o !== 3'b001) begin bad++; $display("FAIL full_ready_again: got %b want 001", bus.req_ready_o); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_backpressure();
        do_reset();
        drive_req(2, 32'h4000_0000, 8'h07, 4'hC);
        bus.req_valid_i     = 3'b100;
        bus.mem_req_ready_i = 1'b0;
        #1;
        total++; if (bus.req_ready_o !== 3'b100) begin bad++; $display("FAIL bp_first: got %b want 100", bus.req_ready_o); end
        @(negedge clk);
        for (int k = 1; k <= 5; k++) begin
            drive_req(2, 32'hDEAD_0000 + k, 8'h01, 4'h2);
            #1;
            total++; if (bus.mem_req_valid_o !== 1'b1) begin bad++; $display("FAIL bp_valid c%0d: got %b want 1", k, bus.mem_req_valid_o); end
            total++; if ({bus.mem_req_addr_o, bus.mem_req_len_o, bus.mem_req_id_o} !== {32'h4000_0000, 8'h07, 2'd2, 4'hC})
                begin bad++; $display("FAIL bp_payload c%0d: got %h/%h/%h want 40000000/07/2c", k, bus.mem_req_addr_o, bus.mem_req_len_o, bus.mem_req_id_o); end
            total++; if (bus.req_ready_o !== 3'b000) begin bad++; $display("FAIL bp_noready c%0d: got %b want 000", k, bus.req_ready_o); end
            @(negedge clk);
        end
        bus.mem_req_ready_i = 1'b1;
        #1;
        total++; if (bus.req_ready_o !== 3'b100) begin bad++; $display("FAIL bp_release: got %b want 100", bus.req_ready_o); end
        @(negedge clk);
        bus.req_valid_i     = 3'b000;
        #1;
        total++; if (bus.mem_req_addr_o !== 32'hDEAD_0005) begin bad++; $display("FAIL bp_next_addr: got %h want dead0005", bus.mem_req_addr_o); end
        total++; if (bus.outst_full_o !== 3'b100) begin bad++; $display("FAIL bp_full: got %b want 100", bus.outst_full_o); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_resp_route();
        int              beat;
        logic            tog;
        logic [DATA_W-1:0] exp_data;
        do_reset();
        drive_req(1, 32'h0000_5000, 8'd3, 4'h3);
        bus.req_valid_i     = 3'b010;
        bus.mem_req_ready_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.req_valid_i = 3'b000;
        #1;
        total++; if (bus.outst_full_o !== 3'b010) begin bad++; $display("FAIL route_pre_full: got %b want 010", bus.outst_full_o); end
        @(negedge clk);
        beat = 0;
        for (int cyc = 0; cyc < 16 && beat < 4; cyc++) begin
            tog      = cyc[0];
            exp_data = 32'hB000 + beat;
            drive_resp(1, 4'h3, exp_data, (beat == 3), {~tog, tog, ~tog});
            #1;
            total++; if (bus.resp_valid_o !== 3'b010) begin bad++; $display("FAIL route_valid b%0d: got %b want 010", beat, bus.resp_valid_o); end
            total++; if (bus.resp_id_o !== 4'h3) begin bad++; $display("FAIL route_id b%0d: got %h want 3", beat, bus.resp_id_o); end
            total++; if (bus.resp_data_o !== exp_data || bus.resp_last_o !== (beat == 3))
                begin bad++; $display("FAIL route_data b%0d: got %h/%b want %h/%b", beat, bus.resp_data_o, bus.resp_last_o, exp_data, (beat == 3)); end
            total++; if (bus.mem_resp_ready_o !== tog) begin bad++; $display("FAIL route_ready b%0d: got %b want %b", beat, bus.mem_resp_ready_o, tog); end
            total++; if (bus.outst_full_o[1] !== 1'b1) begin bad++; $display("FAIL route_cnt_early b%0d: got %b want 1", beat, bus.outst_full_o[1]); end
            if (tog) beat++;
            @(negedge clk);
        end
        idle_inputs();
        #1;
        total++; if (beat !== 4) begin bad++; $display("FAIL route_beats: got %0d want 4", beat); end
        total++; if (bus.outst_full_o !== 3'b000) begin bad++; $display("FAIL route_cnt_after: got %b want 000", bus.outst_full_o); end
        @(negedge clk);
        drive_req(1, 32'h0000_5100, 8'd0, 4'h4);
        bus.req_valid_i     = 3'b010;
        bus.mem_req_ready_i = 1'b1;
        @(negedge clk);
        bus.req_valid_i = 3'b000;
        #1;
        total++; if (bus.outst_full_o !== 3'b010) begin bad++; $display("FAIL route_dec_once: got %b want 010", bus.outst_full_o); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_unrouted();
        do_reset();
        drive_resp(3, 4'h5, 32'hFFFF_0000, 1'b1, 3'b000);
        #1;
        total++; if (bus.mem_resp_ready_o !== 1'b1) begin bad++; $display("FAIL unr_ready: got %b want 1", bus.mem_resp_ready_o); end
        total++; if (bus.resp_valid_o !== 3'b000) begin bad++; $display("FAIL unr_valid: got %b want 000", bus.resp_valid_o); end
        total++; if (bus.unrouted_o !== 1'b0) begin bad++; $display("FAIL unr_pre: got %b want 0", bus.unrouted_o); end
        @(negedge clk);
        bus.mem_resp_valid_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (bus.unrouted_o !== 1'b1) begin bad++; $display("FAIL unr_sticky c%0d: got %b want 1", k, bus.unrouted_o); end
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        total++; if (bus.unrouted_o !== 1'b0) begin bad++; $display("FAIL unr_reset: got %b want 0", bus.unrouted_o); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_same_cycle_async_reset();
        do_reset();
        drive_req(2, 32'h0000_6000, 8'd0, 4'h9);
        bus.req_valid_i     = 3'b100;
        bus.mem_req_ready_i = 1'b1;
        #1;
        total++; if (bus.req_ready_o !== 3'b100) begin bad++; $display("FAIL same_first: got %b want 100", bus.req_ready_o); end
        @(negedge clk);
        drive_resp(2, 4'h9, 32'h0, 1'b1, 3'b100);
        #1;
        total++; if (bus.req_ready_o !== 3'b100 || bus.resp_valid_o !== 3'b100)
            begin bad++; $display("FAIL same_both: got %b/%b want 100/100", bus.req_ready_o, bus.resp_valid_o); end
        @(negedge clk);
        bus.req_valid_i      = 3'b000;
        bus.mem_resp_valid_i = 1'b0;
        #1;
        total++; if (bus.outst_full_o !== 3'b000) begin bad++; $display("FAIL same_cnt_unchanged: got %b want 000", bus.outst_full_o); end
        @(negedge clk);
        bus.req_valid_i = 3'b100;
        #1;
        total++; if (bus.req_ready_o !== 3'b100) begin bad++; $display("FAIL same_second: got %b want 100", bus.req_ready_o); end
        @(negedge clk);
        // hold the next request in the output register and set the sticky flag
        drive_req(0, 32'h0000_7000, 8'd2, 4'h7);
        bus.req_valid_i     = 3'b001;
        bus.mem_req_ready_i = 1'b0;
        drive_resp(3, 4'h0, 32'h0, 1'b0, 3'b000);
        #1;
        total++; if (bus.outst_full_o !== 3'b100) begin bad++; $display("FAIL same_full: got %b want 100", bus.outst_full_o); end
        @(negedge clk);
        bus.mem_resp_valid_i = 1'b0;
        #1;
        total++; if (bus.mem_req_valid_o !== 1'b1 || bus.unrouted_o !== 1'b1)
            begin bad++; $display("FAIL arst_pre: got %b/%b want 1/1", bus.mem_req_valid_o, bus.unrouted_o); end
        #1;
        rst_n = 1'b0;
        #1;
        total++; if (bus.mem_req_valid_o !== 1'b0) begin bad++; $display("FAIL arst_mem_valid: got %b want 0", bus.mem_req_valid_o); end
        total++; if (bus.outst_full_o !== 3'b000) begin bad++; $display("FAIL arst_full: got %b want 000", bus.outst_full_o); end
        total++; if (bus.unrouted_o !== 1'b0) begin bad++; $display("FAIL arst_unrouted: got %b want 0", bus.unrouted_o); end
        total++; if (bus.req_ready_o !== 3'b000) begin bad++; $display("FAIL arst_ready: got %b want 000", bus.req_ready_o); end
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        drive_resp(2, 4'h9, 32'h0, 1'b1, 3'b100);
        #1;
        total++; if (bus.resp_valid_o !== 3'b100) begin bad++; $display("FAIL late_route: got %b want 100", bus.resp_valid_o); end
        @(negedge clk);
        bus.mem_resp_valid_i = 1'b0;
        drive_req(2, 32'h0000_8000, 8'd0, 4'h1);
        bus.req_valid_i     = 3'b100;
        bus.mem_req_ready_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            total++; if (bus.req_ready_o !== 3'b100 || bus.outst_full_o !== 3'b000)
                begin bad++; $display("FAIL late_accept c%0d: got %b/%b want 100/000", k, bus.req_ready_o, bus.outst_full_o); end
            @(negedge clk);
        end
        #1;
        total++; if (bus.outst_full_o !== 3'b100 || bus.req_ready_o !== 3'b000)
            begin bad++; $display("FAIL late_full: got %b/%b want 100/000", bus.outst_full_o, bus.req_ready_o); end
        @(negedge clk);
        idle_inputs();
    endtask

    // ---------------- randomized test with reference model ----------------
    task automatic test_random();
        int                m_cnt [NREQ];
        int                m_ptr;
        bit                m_ov;
        logic [ADDR_W-1:0] m_addr;
        logic [7:0]        m_len;
        logic [MID_W-1:0]  m_id;
        bit                m_unr;
        int                w, q, ridx;
        bit                can;
        logic [NREQ-1:0]   exp_rdy, exp_rv, exp_full;
        logic              exp_mrr;
        logic              rv, rlast;
        logic [NREQ-1:0]   rrdy;
        do_reset();
        for (int p = 0; p < NREQ; p++) m_cnt[p] = 0;
        m_ptr = 0; m_ov = 0; m_addr = '0; m_len = '0; m_id = '0; m_unr = 0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            for (int p = 0; p < NREQ; p++)
                drive_req(p, $urandom, 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
            bus.req_valid_i     = 3'($urandom_range(0, 7));
            bus.mem_req_ready_i = ($urandom_range(0, 3) != 0);
            rv    = $urandom_range(0, 1);
            rlast = $urandom_range(0, 1);
            rrdy  = 3'($urandom_range(0, 7));
            ridx  = ($urandom_range(0, 15) == 0) ? 3 : $urandom_range(0, 2);
            drive_resp(ridx, 4'($urandom_range(0, 15)), $urandom, rlast, rrdy);
            bus.mem_resp_valid_i = rv;
            bus.mem_resp_error_i = $urandom_range(0, 1);
            #1;
            // expected behaviour from the model state
            w = -1;
            for (int i = 0; i < NREQ; i++) begin
                q = (m_ptr + i) % NREQ;
                if (w < 0 && bus.req_valid_i[q] && m_cnt[q] < MAX_OUTST) w = q;
            end
            can = !m_ov || bus.mem_req_ready_i;
            exp_rdy = '0;
            if (can && w >= 0) exp_rdy[w] = 1'b1;
            exp_rv = '0;
            if (ridx < NREQ) begin
                if (rv) exp_rv[ridx] = 1'b1;
                exp_mrr = rrdy[ridx];
            end else begin
                exp_mrr = 1'b1;
            end
            for (int p = 0; p < NREQ; p++) exp_full[p] = (m_cnt[p] == MAX_OUTST);

            total++; if (bus.req_ready_o !== exp_rdy) begin bad++; $display("FAIL rnd_ready c%0d: got %b want %b", cyc, bus.req_ready_o, exp_rdy); end
            total++; if (bus.mem_req_valid_o !== m_ov) begin bad++; $display("FAIL rnd_mem_valid c%0d: got %b want %b", cyc, bus.mem_req_valid_o, m_ov); end
            if (m_ov) begin
                total++; if ({bus.mem_req_addr_o, bus.mem_req_len_o, bus.mem_req_id_o} !== {m_addr, m_len, m_id})
                    begin bad++; $display("FAIL rnd_payload c%0d: got %h/%h/%h want %h/%h/%h", cyc, bus.mem_req_addr_o, bus.mem_req_len_o, bus.mem_req_id_o, m_addr, m_len, m_id); end
            end
            total++; if (bus.resp_valid_o !== exp_rv) begin bad++; $display("FAIL rnd_resp_valid c%0d: got %b want %b", cyc, bus.resp_valid_o, exp_rv); end
            total++; if (bus.mem_resp_ready_o !== exp_mrr) begin bad++; $display("FAIL rnd_resp_ready c%0d: got %b want %b", cyc, bus.mem_resp_ready_o, exp_mrr); end
            total++; if ({bus.resp_id_o, bus.resp_data_o, bus.resp_last_o, bus.resp_error_o} !==
                         {bus.mem_resp_id_i[ID_W-1:0], bus.mem_resp_data_i, rlast, bus.mem_resp_error_i})
                begin bad++; $display("FAIL rnd_resp_payload c%0d: got %h/%h want id %h data %h", cyc, bus.resp_id_o, bus.resp_data_o, bus.mem_resp_id_i[ID_W-1:0], bus.mem_resp_data_i); end
            total++; if (bus.outst_full_o !== exp_full) begin bad++; $display("FAIL rnd_full c%0d: got %b want %b", cyc, bus.outst_full_o, exp_full); end
            total++; if (bus.unrouted_o !== m_unr) begin bad++; $display("FAIL rnd_unrouted c%0d: got %b want %b", cyc, bus.unrouted_o, m_unr); end

            // advance the model across the coming clock edge
            for (int p = 0; p < NREQ; p++) begin
                if (rv && ridx == p && rlast && rrdy[p] && m_cnt[p] > 0) m_cnt[p] = m_cnt[p] - 1;
                if (exp_rdy[p]) m_cnt[p] = m_cnt[p] + 1;
            end
            if (rv && ridx >= NREQ) m_unr = 1;
            if (can) begin
                m_ov = (w >= 0);
                if (w >= 0) begin
                    m_addr = bus.req_addr_i[w*ADDR_W +: ADDR_W];
                    m_len  = bus.req_len_i[w*8 +: 8];
                    m_id   = {IDX_W'(w), bus.req_id_i[w*ID_W +: ID_W]};
                    m_ptr  = (w + 1) % NREQ;
                end
            end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_rr_alternate();
        test_outst_full();
        test_backpressure();
        test_resp_route();
        test_unrouted();
        test_same_cycle_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
